// File: rtl/dp_mode_loader.sv
`default_nettype none
// ============================================================================
// Module   : dp_mode_loader
// Purpose  : Local-bus master that programs the DisplayPort test-pattern
//            timing register block with one of three built-in video modes.
//            A sequence holds the pattern generator in reset (0x00=1), writes
//            the 14 timing registers, releases reset (0x00=0), then reads
//            HEIGHT (0x04) and WIDTH (0x08) back to verify them.
// Ports    :
//   aq_local_clk  in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   level, sampled only while idle; begins a load
//   mode          in   0=1280x720p60 1=1920x1080p60 2=640x480p60 3=reserved
//   busy          out  high from the first bus cycle until done
//   done          out  one-cycle pulse at sequence end (success or error)
//   error         out  sticky, cleared when the next start is accepted
//   err_code      out  0=none 1=bad mode 2=ACK timeout 3=verify mismatch
//   m_cs/m_rnw    out  bus chip-select and read/not-write
//   m_addr        out  byte address, bits 31:8 always 0
//   m_be          out  4'hF during chip-select
//   m_wdata       out  zero-extended 16-bit write value
//   m_ack         in   slave acknowledge
//   m_rdata       in   read data, valid with m_ack on a read
// Revision : 1.0 - initial release
// ============================================================================
module dp_mode_loader #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        aq_local_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        m_cs,
  output logic        m_rnw,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  // Counter only needs to reach ACK_TIMEOUT-1 before the abort fires.
  localparam int            CW       = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  // Entries 0..15 are writes, 16..17 the verify reads; 18 means all done.
  localparam logic [4:0] IDX_READ0 = 5'd16;
  localparam logic [4:0] IDX_END   = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        state;
  logic [4:0]    idx;
  logic [1:0]    mode_q;
  logic          abort;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    addr_q;
  logic [15:0]   wdata_q;

  assign m_addr  = {24'h0, addr_q};
  assign m_wdata = {16'h0, wdata_q};

  // Timing value k (0..13) of mode md, in register-table order starting at
  // HEIGHT. The reserved mode returns zeros; it never reaches the bus.
  function automatic logic [15:0] mode_val(input logic [1:0] md, input logic [3:0] k);
    logic [15:0] v;
    v = 16'd0;
    case (md)
      2'd0: case (k)
        4'd0: v = 16'd750;   4'd1: v = 16'd1650; 4'd2: v = 16'd30;
        4'd3: v = 16'd370;   4'd4: v = 16'd3;    4'd5: v = 16'd8;
        4'd6: v = 16'd0;     4'd7: v = 16'd1650; 4'd8: v = 16'd0;
        4'd9: v = 16'd750;   4'd10: v = 16'd72;  4'd11: v = 16'd152;
        4'd12: v = 16'd270;  4'd13: v = 16'd520;
        default: v = 16'd0;
      endcase
      2'd1: case (k)
        4'd0: v = 16'd1125;  4'd1: v = 16'd2200; 4'd2: v = 16'd45;
        4'd3: v = 16'd280;   4'd4: v = 16'd4;    4'd5: v = 16'd9;
        4'd6: v = 16'd0;     4'd7: v = 16'd2200; 4'd8: v = 16'd0;
        4'd9: v = 16'd1125;  4'd10: v = 16'd88;  4'd11: v = 16'd132;
        4'd12: v = 16'd405;  4'd13: v = 16'd675;
        default: v = 16'd0;
      endcase
      2'd2: case (k)
        4'd0: v = 16'd525;   4'd1: v = 16'd800;  4'd2: v = 16'd45;
        4'd3: v = 16'd160;   4'd4: v = 16'd10;   4'd5: v = 16'd12;
        4'd6: v = 16'd0;     4'd7: v = 16'd800;  4'd8: v = 16'd0;
        4'd9: v = 16'd525;   4'd10: v = 16'd16;  4'd11: v = 16'd112;
        4'd12: v = 16'd120;  4'd13: v = 16'd360;
        default: v = 16'd0;
      endcase
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Byte address of sequence entry k.
  function automatic logic [7:0] entry_addr(input logic [4:0] k);
    logic [7:0] a;
    a = 8'h00;
    if (k >= 5'd1 && k <= 5'd12) a = 8'(k) << 2;  // 0x04..0x30, contiguous
    else if (k == 5'd13)         a = 8'h4C;       // ACTIVE_VIEW start
    else if (k == 5'd14)         a = 8'h50;       // ACTIVE_VIEW end
    else if (k == 5'd16)         a = 8'h04;       // verify HEIGHT
    else if (k == 5'd17)         a = 8'h08;       // verify WIDTH
    else                         a = 8'h00;       // RESET register
    return a;
  endfunction

  // Write value of sequence entry k; reads drive zero.
  function automatic logic [15:0] entry_data(input logic [1:0] md, input logic [4:0] k);
    logic [15:0] d;
    d = 16'd0;
    if (k == 5'd0)                     d = 16'd1;
    else if (k >= 5'd1 && k <= 5'd14)  d = mode_val(md, 4'(k - 5'd1));
    else                               d = 16'd0;
    return d;
  endfunction

  always_ff @(posedge aq_local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= 5'd0;
      mode_q   <= 2'd0;
      abort    <= 1'b0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      m_cs     <= 1'b0;
      m_rnw    <= 1'b0;
      m_be     <= 4'h0;
      addr_q   <= 8'h00;
      wdata_q  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            error    <= 1'b0;
            err_code <= 2'd0;
            abort    <= 1'b0;
            mode_q   <= mode;
            idx      <= 5'd0;
            if (mode == 2'd3) begin
              // Reserved mode: report at once, never touch the bus.
              error    <= 1'b1;
              err_code <= 2'd1;
              done     <= 1'b1;
              state    <= S_FIN;
            end else begin
              state    <= S_REQ;
              busy     <= 1'b1;
              m_cs     <= 1'b1;
              m_be     <= 4'hF;
              m_rnw    <= 1'b0;
              addr_q   <= entry_addr(5'd0);
              wdata_q  <= entry_data(mode, 5'd0);
              wait_cnt <= '0;
            end
          end
        end

        S_REQ: begin
          if (m_ack) begin
            if (m_rnw && !error &&
                ((m_rdata[31:16] != 16'h0000) ||
                 (m_rdata[15:0] != mode_val(mode_q, (idx == IDX_READ0) ? 4'd0 : 4'd1)))) begin
              error    <= 1'b1;
              err_code <= 2'd3;
            end
            idx     <= idx + 5'd1;
            state   <= S_GAP;
            m_cs    <= 1'b0;
            m_be    <= 4'h0;
            m_rnw   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
          end else if (wait_cnt == CNT_LAST) begin
            // Slave never answered: abandon the rest of the table.
            abort   <= 1'b1;
            if (!error) begin
              error    <= 1'b1;
              err_code <= 2'd2;
            end
            state   <= S_GAP;
            m_cs    <= 1'b0;
            m_be    <= 4'h0;
            m_rnw   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // Any ACK here (e.g. a late read ACK) is deliberately ignored.
          if (abort || idx == IDX_END) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_REQ;
            m_cs     <= 1'b1;
            m_be     <= 4'hF;
            m_rnw    <= (idx >= IDX_READ0);
            addr_q   <= entry_addr(idx);
            wdata_q  <= entry_data(mode_q, idx);
            wait_cnt <= '0;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_mode_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dp_mode_loader
// Purpose  : Scoreboard bench for dp_mode_loader. Expected bus transfers are
//            queued when a load is issued; a monitor pops and compares each
//            completed transfer. A behavioural slave with programmable wait,
//            no-ACK and corrupted-WIDTH behaviour answers the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_mode_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic        m_cs, m_rnw, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  dp_mode_loader #(.ACK_TIMEOUT(16)) dut (
    .aq_local_clk (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .m_cs         (m_cs),
    .m_rnw        (m_rnw),
    .m_addr       (m_addr),
    .m_be         (m_be),
    .m_wdata      (m_wdata),
    .m_ack        (m_ack),
    .m_rdata      (m_rdata)
  );

  // ---------------- hand-written register tables ----------------
  int addrs [14] = '{'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C,
                     'h20, 'h24, 'h28, 'h2C, 'h30, 'h4C, 'h50};
  int vals [3][14] = '{
    '{750, 1650, 30, 370, 3, 8, 0, 1650, 0, 750, 72, 152, 270, 520},
    '{1125, 2200, 45, 280, 4, 9, 0, 2200, 0, 1125, 88, 132, 405, 675},
    '{525, 800, 45, 160, 10, 12, 0, 800, 0, 525, 16, 112, 120, 360}};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] regs [64];
  int          cnt = 0;
  int          xfer_cnt = 0;
  int          wait_cyc = 0;
  int          noack_at = -1;
  bit          bad_width = 1'b0;

  initial for (int i = 0; i < 64; i++) regs[i] = 32'h0;

  assign m_ack = m_cs && (cnt == wait_cyc + (m_rnw ? 1 : 0)) && (xfer_cnt != noack_at);
  assign m_rdata = (bad_width && m_addr == 32'h8) ? 32'd799 : regs[m_addr[7:2]];

  always @(posedge clk) begin
    if (m_cs && m_ack) begin
      if (!m_rnw) regs[m_addr[7:2]] <= m_wdata;
      xfer_cnt <= xfer_cnt + 1;
      cnt <= 0;
    end else if (m_cs) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q [$];
  int    cs_cycles = 0;
  int    cs_rises = 0;
  logic  prev_cs = 1'b0;

  task automatic push(input int a, input bit r, input int d);
    xfer_t x;
    x.addr = 32'(a);
    x.rnw  = r;
    x.data = 32'(d);
    exp_q.push_back(x);
  endtask

  // Queue the first n writes of mode md, plus the two verify reads if asked.
  task automatic push_seq(input int md, input int n, input bit reads);
    for (int k = 0; k < n; k++) begin
      if (k == 0)       push(0, 1'b0, 1);
      else if (k == 15) push(0, 1'b0, 0);
      else              push(addrs[k-1], 1'b0, vals[md][k-1]);
    end
    if (reads) begin
      push('h04, 1'b1, 0);
      push('h08, 1'b1, 0);
    end
  endtask

  always @(negedge clk) begin
    xfer_t e;
    if (m_cs) begin
      cs_cycles++;
      if (!prev_cs) cs_rises++;
    end
    prev_cs = m_cs;
    if (m_cs && m_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got addr 0x%0h rnw %0d, expected no transfer", m_addr, m_rnw);
      end else begin
        e = exp_q.pop_front();
        check("xfer_addr", m_addr, e.addr);
        check("xfer_rnw", 32'(m_rnw), 32'(e.rnw));
        check("xfer_be", 32'(m_be), 32'hF);
        if (!e.rnw) check("xfer_wdata", m_wdata, e.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_load(input string tag, input int md, input int exp_done,
                          input int exp_code, input int exp_cs, input int exp_rises);
    int cyc, busy_cnt, cs0, rs0;
    bit got;
    cs0 = cs_cycles;
    rs0 = cs_rises;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'(md);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    busy_cnt = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
    check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
    check({tag, "_error"}, 32'(error), (exp_code != 0) ? 32'h1 : 32'h0);
    check({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), (exp_code == 1) ? 32'h0 : 32'(exp_done - 1));
    check({tag, "_cs_cycles"}, 32'(cs_cycles - cs0), 32'(exp_cs));
    check({tag, "_cs_rises"}, 32'(cs_rises - rs0), 32'(exp_rises));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #1;
    check("reset_outputs", {26'h0, m_cs, busy, done, error, err_code},
          32'h0);
    check("reset_bus", m_addr | m_wdata | {27'h0, m_be, m_rnw}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, zero-wait slave.
    push_seq(0, 16, 1'b1);
    run_load("m0", 0, 39, 0, 20, 18);

    // Mode 1, three wait cycles on every ACK.
    wait_cyc = 3;
    push_seq(1, 16, 1'b1);
    run_load("m1", 1, 93, 0, 74, 18);
    wait_cyc = 0;

    // Mode 2, slave reports WIDTH=799.
    bad_width = 1'b1;
    push_seq(2, 16, 1'b1);
    run_load("m2_verify", 2, 39, 3, 20, 18);
    bad_width = 1'b0;

    // Fifth write never acknowledged: 16 CS cycles then abort.
    noack_at = xfer_cnt + 4;
    push_seq(0, 4, 1'b0);
    run_load("timeout", 0, 26, 2, 20, 5);
    noack_at = -1;

    // Reserved mode, then a good load clears the error.
    run_load("badmode", 3, 1, 1, 0, 0);
    push_seq(0, 16, 1'b1);
    run_load("m0_clear", 0, 39, 0, 20, 18);

    // Asynchronous reset during write 8 (entry 7, REQ on cycle 15).
    push_seq(0, 7, 1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("rst_pre_cs", 32'(m_cs), 32'h1);
    check("rst_pre_addr", m_addr, 32'h1C);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async", {29'h0, m_cs, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int rs0;
      rs0 = cs_rises;
      repeat (6) @(negedge clk);
      check("rst_no_restart", 32'(cs_rises - rs0), 32'h0);
    end
    check("rst_queue_empty", 32'(exp_q.size()), 32'h0);
    push_seq(0, 16, 1'b1);
    run_load("m0_after_rst", 0, 39, 0, 20, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dp_mode_loader.md
# dp_mode_loader

Local-bus master that programs the DisplayPort test-pattern timing register block with one of three built-in video modes. A mode programming sequence holds the pattern generator in reset, writes all timing registers, releases reset, then reads back HEIGHT and WIDTH to verify them. It sits between the system control logic (START/MODE) and the AQ_LOCAL slave port of the timing control registers, on the same clock.

## Interface
- ACK_TIMEOUT, default 255: maximum cycles CS may stay high without ACK before the transfer aborts; minimum 2.
- RST_N  in  1  asynchronous active-low reset
- AQ_LOCAL_CLK  in  1  sole clock, rising edge
- START  in  1  level; sampled only in IDLE; begins a load
- MODE  in  2  0=1280x720p60, 1=1920x1080p60, 2=640x480p60, 3=reserved; captured with START
- BUSY  out  1  high from the first bus cycle until DONE
- DONE  out  1  one-cycle pulse at sequence end, on success or error
- ERROR  out  1  sticky; cleared when the next START is accepted
- ERR_CODE  out  2  0=none, 1=bad mode, 2=ACK timeout, 3=verify mismatch; sticky with ERROR
- M_CS, M_RNW  out  1 each  bus chip-select and read/not-write
- M_ADDR  out  32  byte address; bits 31:8 are always 0
- M_BE  out  4  always 4'hF during CS
- M_WDATA  out  32  write data, zero-extended 16-bit value
- M_ACK  in  1  slave acknowledge; for writes it is combinational in the same cycle as CS; for reads it arrives one cycle later
- M_RDATA  in  32  read data, valid when M_ACK is high on a read

## Operation
- States: IDLE, REQ (CS high, waiting for ACK), GAP (CS low for exactly one cycle, ACK ignored), FIN (DONE pulse), then back to IDLE.
- Write table, 16 entries in this order: 0x00 (RESET)=1, then 0x04 HEIGHT, 0x08 WIDTH, 0x0C ACT_H_START, 0x10 ACT_W_START, 0x14/0x18 VSYNC_V start/end, 0x1C/0x20 VSYNC_H start/end, 0x24/0x28 HSYNC_V start/end, 0x2C/0x30 HSYNC_H start/end, 0x4C/0x50 ACTIVE_VIEW start/end, and finally 0x00=0.
- Mode 0 values: 750, 1650, 30, 370, 3, 8, 0, 1650, 0, 750, 72, 152, 270, 520.
- Mode 1 values: 1125, 2200, 45, 280, 4, 9, 0, 2200, 0, 1125, 88, 132, 405, 675.
- Mode 2 values: 525, 800, 45, 160, 10, 12, 0, 800, 0, 525, 16, 112, 120, 360.
- Verify: after the writes, read 0x04 and then 0x08. A transfer passes only if M_RDATA[15:0] equals the table value and M_RDATA[31:16]==0. A mismatch sets ERR_CODE=3 and completes the remaining read; the first error code is kept.
- MODE=3: no bus activity. Go straight to FIN with ERR_CODE=1.
- Timeout: a per-transfer counter is cleared on REQ entry. If ACK has not arrived within ACK_TIMEOUT cycles, drop CS, set ERR_CODE=2, go to GAP then FIN, and skip all remaining entries. Hardware RESET may be left at 1.
- START while BUSY is ignored. MODE is not re-sampled during a sequence.

## Timing
- Reset values: all outputs 0. The state and table index are cleared asynchronously, so CS drops immediately even mid-transfer.
- The cycle after START is sampled is cycle 1. With a zero-wait slave:
  - writes: REQ on odd cycles 1..31, GAP on even cycles 2..32
  - read 1: REQ on cycles 33-34, GAP on 35
  - read 2: REQ on cycles 36-37, GAP on 38
  - FIN on cycle 39: DONE=1, BUSY=0
- BUSY is high on cycles 1..38. For bad mode, DONE is on cycle 1 and BUSY never rises.
- ADDR, RNW, and WDATA are stable throughout REQ. The transfer completes on the edge where M_ACK=1 in REQ, and the next cycle is GAP.
- An ACK seen in GAP or IDLE (including a stale read ACK) is ignored.
- ERROR and ERR_CODE update on the edge they are detected. They clear on the edge START is accepted.

## Test plan
- Mode 0, zero-wait slave model: 16 writes with the exact addr/data sequence; first write 0x00=1, last 0x00=0; reads return 750 and 1650; DONE on cycle 39; ERROR=0.
- Mode 1, slave inserts 3 wait cycles on every ACK: writes carry 1125/2200 etc.; DONE arrives later by 3 cycles per transfer; ERROR=0; no CS-low cycle is missed between transfers.
- Mode 2, slave returns WIDTH=799: ERR_CODE=3, ERROR=1, both reads still issued, DONE pulses.
- Slave never ACKs the 5th write, ACK_TIMEOUT=16: CS falls after 16 cycles, ERR_CODE=2, no further CS, DONE pulses.
- MODE=3 then START: DONE on cycle 1, ERR_CODE=1, M_CS never high. A subsequent START with MODE=0 clears ERROR.
- RST_N asserted during write 8: CS, BUSY, and DONE go to 0 asynchronously. After release, START is needed to restart, and the full sequence begins at entry 0.
